// File: rtl/adder_err_eval_pkg.sv
// adder_eval_pkg: shared state encoding, width helpers and operand-split
// convention for the adder error evaluator.
package adder_eval_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    // operand A sits in the low half of pi, operand B in the high half
    localparam int OP_A = 0;
    localparam int OP_B = 1;
    function automatic int cnt_w(int num_vec);
        return $clog2(num_vec + 1);
    endfunction
    function automatic int sum_w(int out_w, int num_vec);
        return out_w + cnt_w(num_vec);
    endfunction
    function automatic int op_lsb(int in_w, int idx);
        return idx * (in_w / 2);
    endfunction
endpackage

// File: rtl/adder_err_eval_if.sv
// adder_err_eval_if: valid/ready beat carrying an adder stimulus vector and
// the approximate adder's response.
interface adder_err_eval_if #(parameter int IN_W = 8, parameter int OUT_W = 5);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_pi;
    logic [OUT_W-1:0] in_po;
    modport master (output in_valid, in_pi, in_po, input in_ready);
    modport slave (input in_valid, in_pi, in_po, output in_ready);
endinterface

// File: rtl/adder_err_eval_abs_diff.sv
// abs_diff_u: unsigned |a - b|; the subtraction is widened by one bit so the
// borrow selects the sign.
module abs_diff_u #(parameter int W = 5) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);
    logic [W:0] d;
    assign d = {1'b0, a} - {1'b0, b};
    assign y = d[W] ? W'(-d) : d[W-1:0];
endmodule

// File: rtl/adder_err_eval.sv
// adder_err_eval: consumes (pi, po) beats from an approximate adder, compares po
// with the exact sum and accumulates error count, sum and max of |error|.
module adder_err_eval
    import adder_eval_pkg::*;
#(
    parameter int IN_W    = 8,
    parameter int OUT_W   = 5,
    parameter int NUM_VEC = 256,
    parameter int CNT_W   = cnt_w(NUM_VEC),
    parameter int SUM_W   = sum_w(OUT_W, NUM_VEC)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    adder_err_eval_if.slave   bus,
    output logic              err_flag,
    output logic [IN_W-1:0]   err_pi,
    output logic [CNT_W-1:0]  pat_count,
    output logic [CNT_W-1:0]  err_count,
    output logic [SUM_W-1:0]  sum_abs_err,
    output logic [OUT_W-1:0]  max_abs_err,
    output logic              done
);
    localparam int HW    = IN_W / 2;
    localparam int A_LSB = op_lsb(IN_W, OP_A);
    localparam int B_LSB = op_lsb(IN_W, OP_B);
    state_t state, state_nx;
    logic [CNT_W-1:0] acc;
    logic s1_v, s2_v, take, last, clr;
    logic [OUT_W-1:0] s1_exact, s1_po, s2_abs, abs_w;
    logic [IN_W-1:0] s1_pi, s2_pi;
    assign bus.in_ready = state == RUN;
    assign done = state == DONE;
    assign take = bus.in_valid && bus.in_ready;
    assign last = acc == CNT_W'(NUM_VEC - 1);
    assign clr = start && (state == IDLE || state == DONE);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: state_nx = start ? RUN : state;
            RUN:        state_nx = take && last ? DRAIN : RUN;
            DRAIN:      state_nx = !s1_v && !s2_v ? DONE : DRAIN;
            default:    state_nx = IDLE;
        endcase
    end
    abs_diff_u #(.W(OUT_W)) u_abs (.a(s1_po), .b(s1_exact), .y(abs_w));
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            acc         <= '0;
            s1_v        <= 1'b0;
            s1_exact    <= '0;
            s1_po       <= '0;
            s1_pi       <= '0;
            s2_v        <= 1'b0;
            s2_abs      <= '0;
            s2_pi       <= '0;
            err_flag    <= 1'b0;
            err_pi      <= '0;
            pat_count   <= '0;
            err_count   <= '0;
            sum_abs_err <= '0;
            max_abs_err <= '0;
        end else if (clr) begin
            acc         <= '0;
            s1_v        <= 1'b0;
            s2_v        <= 1'b0;
            err_flag    <= 1'b0;
            err_pi      <= '0;
            pat_count   <= '0;
            err_count   <= '0;
            sum_abs_err <= '0;
            max_abs_err <= '0;
        end else begin
            acc  <= acc + CNT_W'(take);
            s1_v <= take;
            if (take) begin
                s1_exact <= OUT_W'(bus.in_pi[A_LSB +: HW]) + OUT_W'(bus.in_pi[B_LSB +: HW]);
                s1_po    <= bus.in_po;
                s1_pi    <= bus.in_pi;
            end
            s2_v     <= s1_v;
            s2_abs   <= abs_w;
            s2_pi    <= s1_pi;
            err_flag <= s2_v && s2_abs != '0;
            // only committed beats touch the metrics; bubbles just shift through
            if (s2_v) begin
                pat_count   <= pat_count + CNT_W'(1);
                sum_abs_err <= sum_abs_err + SUM_W'(s2_abs);
                if (s2_abs > max_abs_err) max_abs_err <= s2_abs;
                if (s2_abs != '0) begin
                    err_count <= err_count + CNT_W'(1);
                    err_pi    <= s2_pi;
                end
            end
        end
endmodule

// File: tb/tb_adder_err_eval.sv
// tb_adder_err_eval: randomized runs of the error evaluator checked against a
// plain-arithmetic model of exact sums and error metrics.
module tb_adder_err_eval;
    localparam int IN_W = 8, OUT_W = 5;
    logic clk = 1'b0, rst_n = 1'b0, start0 = 1'b0, start1 = 1'b0;
    bit sel = 1'b0;
    int vectors = 0, miscompares = 0;
    always #5 clk = ~clk;
    adder_err_eval_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus0 ();
    adder_err_eval_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus1 ();
    assign bus1.in_valid = bus0.in_valid;
    assign bus1.in_pi    = bus0.in_pi;
    assign bus1.in_po    = bus0.in_po;
    logic ef0, dn0, ef1, dn1;
    logic [7:0] epi0, epi1;
    logic [8:0] pc0, ec0;
    logic [7:0] pc1, ec1;
    logic [13:0] sae0;
    logic [12:0] sae1;
    logic [4:0] mae0, mae1;
    adder_err_eval #(.IN_W(IN_W), .OUT_W(OUT_W), .NUM_VEC(256)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .bus(bus0), .err_flag(ef0), .err_pi(epi0),
        .pat_count(pc0), .err_count(ec0), .sum_abs_err(sae0), .max_abs_err(mae0), .done(dn0));
    adder_err_eval #(.IN_W(IN_W), .OUT_W(OUT_W), .NUM_VEC(255)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .bus(bus1), .err_flag(ef1), .err_pi(epi1),
        .pat_count(pc1), .err_count(ec1), .sum_abs_err(sae1), .max_abs_err(mae1), .done(dn1));
    logic rdy_s, dn_s, ef_s;
    logic [7:0] epi_s;
    logic [8:0] pc_s, ec_s;
    logic [13:0] sae_s;
    logic [4:0] mae_s;
    always_comb begin
        rdy_s = sel ? bus1.in_ready : bus0.in_ready;
        dn_s  = sel ? dn1 : dn0;
        ef_s  = sel ? ef1 : ef0;
        epi_s = sel ? epi1 : epi0;
        pc_s  = sel ? 9'(pc1) : pc0;
        ec_s  = sel ? 9'(ec1) : ec0;
        sae_s = sel ? 14'(sae1) : sae0;
        mae_s = sel ? mae1 : mae0;
    end
    // modes: 0 exact, 1 po=0, 2 exact except pi=FF gives 0, 3 exact+1, 4 random po
    function automatic logic [4:0] po_for(int mode, logic [7:0] pi);
        int ex;
        ex = int'(pi[3:0]) + int'(pi[7:4]);
        case (mode)
            1: return 5'd0;
            2: return pi == 8'hFF ? 5'd0 : 5'(ex);
            3: return 5'(ex + 1);
            4: return 5'($urandom_range(31));
            default: return 5'(ex);
        endcase
    endfunction
    task automatic run(input bit d, input int n, input int lim, input int mode, input int bub,
                       input bit extra, input string nm);
        int i, cyc, flags, first, e_err, e_sum, e_max, e_pi, ex, ab;
        logic [7:0] pi;
        logic [4:0] po;
        sel = d; i = 0; cyc = 0; flags = 0; first = 0;
        e_err = 0; e_sum = 0; e_max = 0; e_pi = 0;
        if (extra) repeat (3) begin
            @(negedge clk);
            bus0.in_valid = 1'b1; bus0.in_pi = 8'($urandom); bus0.in_po = 5'($urandom);
        end
        @(negedge clk);
        if (d) start1 = 1'b1; else start0 = 1'b1;
        bus0.in_valid = extra; bus0.in_pi = 8'($urandom); bus0.in_po = 5'($urandom);
        while (i < lim) begin
            @(negedge clk);
            cyc++;
            start0 = 1'b0; start1 = 1'b0;
            flags += int'(ef_s);
            if (cyc == 1) begin
                vectors++;
                if (dn_s !== 1'b0) begin miscompares++; $display("FAIL %s done_after_start got %b want 0", nm, dn_s); end
            end
            vectors++;
            if (rdy_s !== 1'b1) begin miscompares++; $display("FAIL %s in_ready_run beat %0d got %b want 1", nm, i, rdy_s); end
            if ($urandom_range(99) < bub) begin
                bus0.in_valid = 1'b0; bus0.in_pi = 8'($urandom); bus0.in_po = 5'($urandom);
            end else begin
                pi = mode == 4 ? 8'($urandom) : 8'(i);
                po = po_for(mode, pi);
                bus0.in_valid = 1'b1; bus0.in_pi = pi; bus0.in_po = po;
                ex = int'(pi[3:0]) + int'(pi[7:4]);
                ab = int'(po) > ex ? int'(po) - ex : ex - int'(po);
                if (ab != 0) begin e_err++; e_pi = int'(pi); end
                e_sum += ab;
                if (ab > e_max) e_max = ab;
                i++;
            end
        end
        if (lim < n) return;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            flags += int'(ef_s);
            if (k == 1 || k == 8) begin
                vectors++;
                if (rdy_s !== 1'b0) begin miscompares++; $display("FAIL %s in_ready_after_last k=%0d got %b want 0", nm, k, rdy_s); end
            end
            if (dn_s === 1'b1 && first == 0) first = k;
            bus0.in_valid = extra; bus0.in_pi = 8'($urandom); bus0.in_po = 5'($urandom);
        end
        bus0.in_valid = 1'b0;
        vectors++;
        if (first != 4) begin miscompares++; $display("FAIL %s done_latency got %0d want 4 (0=never)", nm, first); end
        vectors++;
        if (pc_s !== 9'(n)) begin miscompares++; $display("FAIL %s pat_count got %0d want %0d", nm, pc_s, n); end
        vectors++;
        if (ec_s !== 9'(e_err)) begin miscompares++; $display("FAIL %s err_count got %0d want %0d", nm, ec_s, e_err); end
        vectors++;
        if (sae_s !== 14'(e_sum)) begin miscompares++; $display("FAIL %s sum_abs_err got %0d want %0d", nm, sae_s, e_sum); end
        vectors++;
        if (mae_s !== 5'(e_max)) begin miscompares++; $display("FAIL %s max_abs_err got %0d want %0d", nm, mae_s, e_max); end
        vectors++;
        if (flags != e_err) begin miscompares++; $display("FAIL %s err_flag_cycles got %0d want %0d", nm, flags, e_err); end
        if (e_err > 0) begin
            vectors++;
            if (epi_s !== 8'(e_pi)) begin miscompares++; $display("FAIL %s err_pi got %h want %h", nm, epi_s, 8'(e_pi)); end
        end
    endtask
    task automatic check_zero(input string nm);
        vectors++;
        if ({rdy_s, dn_s, ef_s} !== 3'b0) begin miscompares++; $display("FAIL %s ready/done/flag got %b want 000", nm, {rdy_s, dn_s, ef_s}); end
        vectors++;
        if (epi_s !== 8'd0) begin miscompares++; $display("FAIL %s err_pi got %h want 00", nm, epi_s); end
        vectors++;
        if ({pc_s, ec_s} !== 18'd0) begin miscompares++; $display("FAIL %s counts got %0d/%0d want 0/0", nm, pc_s, ec_s); end
        vectors++;
        if ({sae_s, mae_s} !== 19'd0) begin miscompares++; $display("FAIL %s sum/max got %0d/%0d want 0/0", nm, sae_s, mae_s); end
    endtask
    task automatic test_reset;
        sel = 1'b0;
        @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_zero("idle");
    endtask
    task automatic test_reset_mid_run;
        run(1'b0, 256, 100, 1, 0, 1'b0, "pre_rst");
        @(negedge clk);
        vectors++;
        if (pc_s == 9'd0) begin miscompares++; $display("FAIL mid_run pat_count got 0 want nonzero"); end
        rst_n = 1'b0; bus0.in_valid = 1'b0;
        #1;
        check_zero("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_zero("post_reset_idle");
        run(1'b0, 256, 256, 0, 10, 1'b0, "after_rst");
    endtask
    initial begin
        bus0.in_valid = 1'b0; bus0.in_pi = '0; bus0.in_po = '0;
        test_reset();
        run(1'b0, 256, 256, 0, 0, 1'b0, "exact");
        run(1'b0, 256, 256, 1, 0, 1'b0, "po_zero");
        run(1'b0, 256, 256, 2, 0, 1'b0, "single_err");
        run(1'b0, 256, 256, 0, 30, 1'b1, "bubbles");
        run(1'b0, 256, 256, 4, 20, 1'b1, "random_po");
        test_reset_mid_run();
        run(1'b1, 255, 255, 3, 0, 1'b0, "num_vec_255");
        run(1'b1, 255, 255, 4, 25, 1'b1, "back_to_back_255");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
